// File: rtl/wam_pkg.sv
// Shared constants, repeat-FSM state encoding and hit encoder helpers.
package wam_pkg;

   localparam int unsigned N_HOLE      = 8;
   localparam int unsigned WAM_DB_CNT  = 3;
   localparam int unsigned WAM_REP_DLY = 96;
   localparam int unsigned WAM_REP_PER = 24;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rep_st_t;

   // Lowest-index priority encoder; 0 when no bit is set.
   function automatic logic [2:0] low_idx(input logic [N_HOLE-1:0] v);
      logic [2:0] idx;
      idx = '0;
      for (int i = N_HOLE - 1; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   // Two or more bits set: clearing the lowest set bit leaves something.
   function automatic logic multi_hot(input logic [N_HOLE-1:0] v);
      return |(v & (v - N_HOLE'(1)));
   endfunction

endpackage

// File: rtl/wam_btn_if.sv
// Button-side bundle: raw buttons in, conditioned pulses and hit encoding out.
interface wam_btn_if;
   import wam_pkg::*;

   logic [N_HOLE-1:0] btn_hole;
   logic              btn_lft;
   logic              btn_rgt;
   logic [N_HOLE-1:0] tap;
   logic              lft;
   logic              rgt;
   logic              hit_vld;
   logic [2:0]        hit_idx;
   logic              multi;

   // Board / stimulus side drives the raw buttons.
   modport master (
      output btn_hole, btn_lft, btn_rgt,
      input  tap, lft, rgt, hit_vld, hit_idx, multi
   );

   // Conditioner side.
   modport slave (
      input  btn_hole, btn_lft, btn_rgt,
      output tap, lft, rgt, hit_vld, hit_idx, multi
   );
endinterface

// File: rtl/wam_dbn.sv
// One-bit synchroniser, debouncer and rising-edge detector.
module wam_dbn #(
   parameter int unsigned DB_CNT = 3
) (
   input  logic clk_19,
   input  logic rst_n,
   input  logic raw,
   output logic deb,
   output logic rise
);

   logic       s1_q, s2_q;
   logic       d_q, d_dly_q;
   logic [2:0] c_q;

   // Two-flop synchroniser for the asynchronous button level.
   always_ff @(posedge clk_19 or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
      end
   end

   // Flip the debounced level only after DB_CNT consecutive disagreeing samples.
   always_ff @(posedge clk_19 or negedge rst_n) begin
      if (!rst_n) begin
         d_q <= 1'b0;
         c_q <= '0;
      end else if (s2_q == d_q) begin
         c_q <= '0;
      end else if (c_q == 3'(DB_CNT - 1)) begin
         d_q <= ~d_q;
         c_q <= '0;
      end else begin
         c_q <= c_q + 3'd1;
      end
   end

   // Delayed copy of the debounced level for edge detection.
   always_ff @(posedge clk_19 or negedge rst_n) begin
      if (!rst_n) begin
         d_dly_q <= 1'b0;
      end else begin
         d_dly_q <= d_q;
      end
   end

   assign deb  = d_q;
   // Combinational here; registered by the top together with the encoder.
   assign rise = d_q & ~d_dly_q;

endmodule

// File: rtl/wam_btn.sv
// Whack-a-mole input conditioner: hole tap pulses, hit encoder, lft/rgt auto-repeat.
module wam_btn
   import wam_pkg::*;
#(
   parameter int unsigned DB_CNT  = WAM_DB_CNT,
   parameter int unsigned REP_DLY = WAM_REP_DLY,
   parameter int unsigned REP_PER = WAM_REP_PER
) (
   input  logic     clk_19,
   input  logic     rst_n,
   wam_btn_if.slave bus
);

   logic [N_HOLE-1:0] hole_rise;
   logic              deb_lft, deb_rgt;
   logic              both;

   logic [N_HOLE-1:0] tap_q;
   logic              hit_vld_q, multi_q;
   logic [2:0]        hit_idx_q;
   logic              lft_q, rgt_q;

   rep_st_t    lft_st_q, lft_st_d, rgt_st_q, rgt_st_d;
   logic [6:0] lft_r_q, lft_r_d, rgt_r_q, rgt_r_d;
   logic       lft_p_d, rgt_p_d;

   for (genvar i = 0; i < N_HOLE; i++) begin : g_hole
      logic deb_unused;
      wam_dbn #(.DB_CNT(DB_CNT)) u_dbn (
         .clk_19 (clk_19),
         .rst_n  (rst_n),
         .raw    (bus.btn_hole[i]),
         .deb    (deb_unused),
         .rise   (hole_rise[i])
      );
   end

   logic lft_rise_unused, rgt_rise_unused;

   wam_dbn #(.DB_CNT(DB_CNT)) u_dbn_lft (
      .clk_19 (clk_19),
      .rst_n  (rst_n),
      .raw    (bus.btn_lft),
      .deb    (deb_lft),
      .rise   (lft_rise_unused)
   );

   wam_dbn #(.DB_CNT(DB_CNT)) u_dbn_rgt (
      .clk_19 (clk_19),
      .rst_n  (rst_n),
      .raw    (bus.btn_rgt),
      .deb    (deb_rgt),
      .rise   (rgt_rise_unused)
   );

   // Conflicting directions held together cancel each other.
   assign both = deb_lft & deb_rgt;

   // Left repeat FSM next state; IDLE entry is level-based so a survivor of a
   // both-held period restarts with a fresh pulse.
   always_comb begin
      lft_st_d = lft_st_q;
      lft_r_d  = lft_r_q;
      lft_p_d  = 1'b0;
      if (!deb_lft || both) begin
         lft_st_d = IDLE;
         lft_r_d  = '0;
      end else begin
         unique case (lft_st_q)
            IDLE: begin
               lft_st_d = DELAY;
               lft_r_d  = '0;
               lft_p_d  = 1'b1;
            end
            DELAY: begin
               if (lft_r_q == 7'(REP_DLY - 1)) begin
                  lft_st_d = REPEAT;
                  lft_r_d  = '0;
                  lft_p_d  = 1'b1;
               end else begin
                  lft_r_d = lft_r_q + 7'd1;
               end
            end
            REPEAT: begin
               if (lft_r_q == 7'(REP_PER - 1)) begin
                  lft_r_d = '0;
                  lft_p_d = 1'b1;
               end else begin
                  lft_r_d = lft_r_q + 7'd1;
               end
            end
            default: begin
               lft_st_d = IDLE;
               lft_r_d  = '0;
            end
         endcase
      end
   end

   // Right repeat FSM next state, mirror of the left one.
   always_comb begin
      rgt_st_d = rgt_st_q;
      rgt_r_d  = rgt_r_q;
      rgt_p_d  = 1'b0;
      if (!deb_rgt || both) begin
         rgt_st_d = IDLE;
         rgt_r_d  = '0;
      end else begin
         unique case (rgt_st_q)
            IDLE: begin
               rgt_st_d = DELAY;
               rgt_r_d  = '0;
               rgt_p_d  = 1'b1;
            end
            DELAY: begin
               if (rgt_r_q == 7'(REP_DLY - 1)) begin
                  rgt_st_d = REPEAT;
                  rgt_r_d  = '0;
                  rgt_p_d  = 1'b1;
               end else begin
                  rgt_r_d = rgt_r_q + 7'd1;
               end
            end
            REPEAT: begin
               if (rgt_r_q == 7'(REP_PER - 1)) begin
                  rgt_r_d = '0;
                  rgt_p_d = 1'b1;
               end else begin
                  rgt_r_d = rgt_r_q + 7'd1;
               end
            end
            default: begin
               rgt_st_d = IDLE;
               rgt_r_d  = '0;
            end
         endcase
      end
   end

   // Repeat FSM state and counter registers.
   always_ff @(posedge clk_19 or negedge rst_n) begin
      if (!rst_n) begin
         lft_st_q <= IDLE;
         lft_r_q  <= '0;
         rgt_st_q <= IDLE;
         rgt_r_q  <= '0;
      end else begin
         lft_st_q <= lft_st_d;
         lft_r_q  <= lft_r_d;
         rgt_st_q <= rgt_st_d;
         rgt_r_q  <= rgt_r_d;
      end
   end

   // Output registers; encoder works on the same-cycle rise vector so it
   // lines up with tap.
   always_ff @(posedge clk_19 or negedge rst_n) begin
      if (!rst_n) begin
         tap_q     <= '0;
         hit_vld_q <= 1'b0;
         hit_idx_q <= '0;
         multi_q   <= 1'b0;
         lft_q     <= 1'b0;
         rgt_q     <= 1'b0;
      end else begin
         tap_q     <= hole_rise;
         hit_vld_q <= |hole_rise;
         hit_idx_q <= low_idx(hole_rise);
         multi_q   <= multi_hot(hole_rise);
         lft_q     <= lft_p_d;
         rgt_q     <= rgt_p_d;
      end
   end

   assign bus.tap     = tap_q;
   assign bus.hit_vld = hit_vld_q;
   assign bus.hit_idx = hit_idx_q;
   assign bus.multi   = multi_q;
   assign bus.lft     = lft_q;
   assign bus.rgt     = rgt_q;

endmodule

// File: tb/tb_wam_btn.sv
// Directed self-checking bench for wam_btn with default parameters.
module tb_wam_btn;

   localparam int unsigned DB_CNT  = 3;
   localparam int unsigned REP_DLY = 96;
   localparam int unsigned REP_PER = 24;

   logic clk_19;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   int   pos[$];
   int   extra;

   wam_btn_if bus ();

   wam_btn #(
      .DB_CNT  (DB_CNT),
      .REP_DLY (REP_DLY),
      .REP_PER (REP_PER)
   ) dut (
      .clk_19 (clk_19),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   initial clk_19 = 1'b0;
   always #5 clk_19 = ~clk_19;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are stable 1 time unit after the edge.
   task automatic tick();
      @(posedge clk_19);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [31:0] all_out();
      return {16'h0, bus.tap, bus.lft, bus.rgt, bus.hit_vld, bus.hit_idx, bus.multi};
   endfunction

   initial begin
      int exp_rgt[6];
      int exp_lft[3];
      exp_rgt = '{0, 96, 120, 144, 168, 192};
      exp_lft = '{6, 156, 252};
      n_chk  = 0;
      n_fail = 0;

      assert (DB_CNT >= 1 && DB_CNT <= 7 && REP_DLY >= 2 && REP_DLY <= 127 &&
              REP_PER >= 1 && REP_PER <= 127 && REP_PER <= REP_DLY)
      else $error("FAIL param_range: illegal parameter set");

      rst_n        = 1'b0;
      bus.btn_hole = '0;
      bus.btn_lft  = 1'b0;
      bus.btn_rgt  = 1'b0;
      #2;
      check("reset_outs", all_out(), 32'h0);
      idle(3);
      check("reset_outs_clk", all_out(), 32'h0);
      rst_n = 1'b1;
      idle(5);
      check("idle_outs", all_out(), 32'h0);

      // Hole 5 held clean: single tap 6 ticks after the drive (E+5).
      bus.btn_hole = 8'h20;
      extra = 0;
      for (int i = 1; i <= 205; i++) begin
         tick();
         if (i == 6) begin
            check("h5_tap", 32'(bus.tap), 32'h20);
            check("h5_idx", 32'(bus.hit_idx), 32'd5);
            check("h5_vld", 32'(bus.hit_vld), 32'd1);
            check("h5_multi", 32'(bus.multi), 32'd0);
         end else if (bus.tap != 0 || bus.hit_vld) begin
            extra++;
         end
      end
      check("h5_no_repeat", 32'(extra), 32'd0);
      bus.btn_hole = '0;
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.tap != 0) extra++;
      end
      check("h5_release", 32'(extra), 32'd0);

      // Hole 2 bouncing 1-0-1-0, then steady high.
      pos.delete();
      for (int i = 0; i < 4; i++) begin
         bus.btn_hole = (i % 2 == 0) ? 8'h04 : 8'h00;
         tick();
         if (bus.tap != 0) pos.push_back(-1);
      end
      bus.btn_hole = 8'h04;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.tap != 0) pos.push_back(i);
      end
      check("h2_tap_count", 32'(pos.size()), 32'd1);
      if (pos.size() > 0) check("h2_tap_time", 32'(pos[0]), 32'd6);
      bus.btn_hole = '0;
      idle(12);

      // Holes 1 and 6 together.
      bus.btn_hole = 8'h42;
      idle(6);
      check("h16_tap", 32'(bus.tap), 32'h42);
      check("h16_idx", 32'(bus.hit_idx), 32'd1);
      check("h16_multi", 32'(bus.multi), 32'd1);
      check("h16_vld", 32'(bus.hit_vld), 32'd1);
      tick();
      check("h16_width", all_out(), 32'h0);
      bus.btn_hole = '0;
      idle(12);

      // Right held 200 cycles after its first pulse.
      pos.delete();
      bus.btn_rgt = 1'b1;
      for (int i = 1; i <= 205; i++) begin
         tick();
         if (bus.rgt) pos.push_back(i);
      end
      check("rgt_count", 32'(pos.size()), 32'd6);
      if (pos.size() > 0) check("rgt_first", 32'(pos[0]), 32'd6);
      for (int k = 1; k < 6; k++) begin
         if (k < pos.size()) check($sformatf("rgt_rel%0d", k), 32'(pos[k] - pos[0]), 32'(exp_rgt[k]));
      end
      bus.btn_rgt = 1'b0;
      extra = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.rgt) extra++;
      end
      check("rgt_release", 32'(extra), 32'd0);
      // Fresh press after release: back in IDLE, so normal latency.
      pos.delete();
      bus.btn_rgt = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (bus.rgt) pos.push_back(i);
      end
      check("rgt_repress_count", 32'(pos.size()), 32'd1);
      if (pos.size() > 0) check("rgt_repress_time", 32'(pos[0]), 32'd6);
      bus.btn_rgt = 1'b0;
      idle(12);

      // Left held, right joins at 50 and leaves at 150.
      pos.delete();
      extra = 0;
      bus.btn_lft = 1'b1;
      for (int i = 1; i <= 260; i++) begin
         tick();
         if (bus.lft) pos.push_back(i);
         if (bus.rgt) extra++;
         if (i == 50) bus.btn_rgt = 1'b1;
         if (i == 150) bus.btn_rgt = 1'b0;
      end
      check("both_rgt_quiet", 32'(extra), 32'd0);
      check("both_lft_count", 32'(pos.size()), 32'd3);
      for (int k = 0; k < 3; k++) begin
         if (k < pos.size()) check($sformatf("both_lft%0d", k), 32'(pos[k]), 32'(exp_lft[k]));
      end

      // Reset asserted during a repeat pulse with left still held.
      idle(16);
      check("lft_pre_rst", 32'(bus.lft), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_async", all_out(), 32'h0);
      idle(3);
      check("rst_hold", all_out(), 32'h0);
      rst_n = 1'b1;
      pos.delete();
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (bus.lft) pos.push_back(i);
      end
      check("rst_lft_count", 32'(pos.size()), 32'd1);
      if (pos.size() > 0) check("rst_lft_time", 32'(pos[0]), 32'd6);
      bus.btn_lft = 1'b0;
      idle(10);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wam_btn.md
# wam_btn

Input conditioner for the whack-a-mole board: samples the eight raw hole push-buttons and the left/right hardness buttons on the slow `clk_19` tick. It synchronises, debounces and edge-detects each button, then emits one-cycle pulses. The tap pulses feed the game core and the digit-flash logic. Left/right get auto-repeat while held. The block also provides an encoded hit index for the score logic. It is the input-side counterpart of the LED/7-segment display path.

## Interface
Parameters:
- `DB_CNT`, 3: consecutive agreeing synced samples required to flip a debounced state; legal range 1..7.
- `REP_DLY`, 96: hold cycles from first lft/rgt pulse to first repeat (~0.5 s at `clk_19`); legal range 2..127.
- `REP_PER`, 24: cycles between subsequent repeats; legal range 1..127, ≤ `REP_DLY`.

Ports:
- `clk_19` in 1: sampling clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_hole` in 8: raw hole buttons, active-high, asynchronous.
- `btn_lft` in 1: raw hardness-down button.
- `btn_rgt` in 1: raw hardness-up button.
- `tap` out 8: one-cycle press pulse per hole.
- `lft` out 1: hardness-down pulse, with auto-repeat.
- `rgt` out 1: hardness-up pulse, with auto-repeat.
- `hit_vld` out 1: high when any `tap` bit is high.
- `hit_idx` out 3: index of the lowest set `tap` bit; 0 when `hit_vld`=0.
- `multi` out 1: high when two or more `tap` bits are high in the same cycle.

## Operation
- Every input passes through a 2-FF synchroniser, then a per-button debouncer.
- Debouncer:
  - Holds state `d`, reset 0, and a counter `c` of width 3.
  - Synced value equals `d`: `c` ← 0.
  - Synced value differs and `c` = `DB_CNT`−1: `d` flips and `c` ← 0.
  - Otherwise `c` increments.
- Any glitch shorter than `DB_CNT` samples is fully discarded. The counter restarts from 0 on every agreement.
- `tap[i]` is high exactly in the cycle after `d[i]` rises. Releases produce no pulse.
- `hit_vld`, `hit_idx` and `multi` are derived from the same-cycle `tap` vector. `hit_idx` uses a lowest-index priority encoder.
- Repeat FSM, one per direction (states IDLE, DELAY, REPEAT), 7-bit counter `r`:
  - IDLE → DELAY on debounced press. Emit the pulse and set `r` ← 0.
  - DELAY: `r` increments. At `r` = `REP_DLY`−1, emit a pulse, set `r` ← 0, go to REPEAT.
  - REPEAT: `r` increments. At `r` = `REP_PER`−1, emit a pulse and set `r` ← 0.
  - Debounced release from any state → IDLE with no pulse.
- Both directions debounced-held in the same cycle:
  - Both FSMs are forced to IDLE and both `lft` and `rgt` stay 0.
  - Once one button is released, the still-held one re-enters via IDLE → DELAY with a fresh pulse.
- Hole buttons have no auto-repeat. Hole taps and lft/rgt pulses are independent and may coincide.

## Timing
- Reset (async assert, synchronous-effect deassert): every output is 0, and all synchroniser, debounce, counter and FSM state is 0/IDLE.
- A button held through reset release is seen as a new press and produces one pulse after the normal latency.
- Latency:
  - Raw level first captured at edge E gives `d` rising at edge E+1+`DB_CNT` and the `tap`/`lft`/`rgt` pulse registered at edge E+2+`DB_CNT`.
  - With the default `DB_CNT`=3 the pulse appears at edge E+5.
- All outputs are registered. The pulse width is exactly 1 cycle.
- Repeat spacing, measured pulse-to-pulse: first repeat `REP_DLY` cycles after the initial pulse, then every `REP_PER` cycles.
- Repeat counter wrap: `r` never exceeds 126. Parameters above 127 are illegal, and the bench checks them with an assertion.
- Reset mid-hold or mid-debounce: the state is discarded. After release, behaviour is as for a fresh press.

## Structure
- Shared package `wam_pkg`:
  - `N_HOLE`=8.
  - Default constants `WAM_DB_CNT`, `WAM_REP_DLY`, `WAM_REP_PER`.
  - FSM state encoding `rep_st_t` (IDLE=0, DELAY=1, REPEAT=2).
- Sub-module `wam_dbn`: synchroniser plus debouncer plus rise pulse, one bit wide. Instantiated 10 times.
- The repeat FSM is written inline, twice. The encoder is combinational logic feeding the output registers.

## Test plan
- Hole 5 held clean from edge 10: `tap`=8'h20 for exactly one cycle at edge 15, `hit_idx`=5, `hit_vld`=1, `multi`=0. No further pulse for 200 cycles of hold.
- Hole 2 bouncing 1-0-1-0 on alternating cycles, then steady high: no `tap` during the bounce. A single `tap[2]` appears 5 edges after the steady high begins.
- Holes 1 and 6 pressed in the same cycle: `tap`=8'h42, `hit_idx`=1, `multi`=1 for one cycle.
- `btn_rgt` held 200 cycles (defaults): `rgt` pulses at relative cycles 0, 96, 120, 144, 168, 192. Release gives no pulse and the FSM returns to IDLE.
- `btn_lft` held, then `btn_rgt` added at cycle 50, then `btn_rgt` released at cycle 150: no pulses at all while both are held. After the release, `lft` pulses again and the 96-cycle delay restarts.
- `rst_n` pulsed low mid-repeat with `btn_lft` still held: all outputs 0 immediately. The first pulse arrives 5 edges after reset deasserts.
